// File: rtl/sistema_ula_param.sv
// sistema_ula_param: push-button ALU with sequential binary-to-BCD conversion.
// The operator enters operand A, operand B and the opcode on `switches`,
// one button press each. The block then executes the operation, registers
// the result and flags, and converts |result| to packed BCD (double dabble,
// one bit per cycle).
//
// Ports:
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   push_button  raw (debounced) button, active-high, asynchronous to clk
//   switches     operand / opcode entry (opcode on switches[2:0])
//   a_val/b_val  latched operands
//   op_val       latched opcode
//   state        current FSM state code
//   result       registered two's-complement result, 2*WIDTH bits
//   led_zero/led_neg/led_overflow  registered flags
//   result_bcd   packed BCD magnitude of result, digit 0 in [3:0]
//   busy         high in EXEC and CONVERT
//   done         one-cycle pulse on entry to SHOW
module sistema_ula_param #(
  parameter int WIDTH  = 3,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_button,
  input  logic [WIDTH-1:0]      switches,
  output logic [WIDTH-1:0]      a_val,
  output logic [WIDTH-1:0]      b_val,
  output logic [2:0]            op_val,
  output logic [2:0]            state,
  output logic [2*WIDTH-1:0]    result,
  output logic                  led_zero,
  output logic                  led_neg,
  output logic                  led_overflow,
  output logic [4*DIGITS-1:0]   result_bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int RES_W = 2 * WIDTH;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(RES_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_W - 1);

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] CONVERT = 3'd4;
  localparam logic [2:0] SHOW    = 3'd5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // Button synchroniser and edge detector
  logic sync1, sync2, prev;
  logic press;

  assign press = sync2 & ~prev;

  // ALU datapath (combinational, consumed in EXEC)
  logic [RES_W-1:0] a_ext, b_ext;
  logic [RES_W-1:0] alu_res, alu_mag;
  logic             alu_neg, alu_ovf;

  always_comb begin
    a_ext   = {{(RES_W-WIDTH){1'b0}}, a_val};
    b_ext   = {{(RES_W-WIDTH){1'b0}}, b_val};
    alu_res = '0;
    alu_neg = 1'b0;
    case (op_val)
      OP_ADD: alu_res = a_ext + b_ext;
      OP_SUB: begin
        alu_res = a_ext - b_ext;
        alu_neg = (a_val < b_val);
      end
      OP_AND: alu_res = a_ext & b_ext;
      OP_OR:  alu_res = a_ext | b_ext;
      OP_XOR: alu_res = a_ext ^ b_ext;
      OP_NOT: alu_res = {{(RES_W-WIDTH){1'b0}}, ~a_val};
      OP_MUL: alu_res = a_ext * b_ext;
      OP_SHL: alu_res = a_ext << b_val[1:0];
      default: alu_res = '0;
    endcase
    // Only the growing operations can exceed the operand width.
    alu_ovf = ((op_val == OP_ADD) || (op_val == OP_MUL) || (op_val == OP_SHL))
              && (|alu_res[RES_W-1:WIDTH]);
    alu_mag = alu_neg ? (-alu_res) : alu_res;
  end

  // Double-dabble shift registers
  logic [RES_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh;
  logic [BCD_W-1:0] bcd_adj, bcd_next;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_sh[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin_sh[RES_W-1]};
  end

  assign busy = (state == EXEC) || (state == CONVERT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      state        <= LOAD_A;
      a_val        <= '0;
      b_val        <= '0;
      op_val       <= '0;
      result       <= '0;
      led_zero     <= 1'b0;
      led_neg      <= 1'b0;
      led_overflow <= 1'b0;
      result_bcd   <= '0;
      bin_sh       <= '0;
      bcd_sh       <= '0;
      cnt          <= '0;
      done         <= 1'b0;
    end else begin
      sync1 <= push_button;
      sync2 <= sync1;
      prev  <= sync2;
      done  <= 1'b0;
      case (state)
        LOAD_A: if (press) begin
          a_val <= switches;
          state <= LOAD_B;
        end
        LOAD_B: if (press) begin
          b_val <= switches;
          state <= LOAD_OP;
        end
        LOAD_OP: if (press) begin
          op_val <= switches[2:0];
          state  <= EXEC;
        end
        EXEC: begin
          result       <= alu_res;
          led_zero     <= (alu_res == '0);
          led_neg      <= alu_neg;
          led_overflow <= alu_ovf;
          bin_sh       <= alu_mag;
          bcd_sh       <= '0;
          cnt          <= '0;
          state        <= CONVERT;
        end
        CONVERT: begin
          bcd_sh <= bcd_next;
          bin_sh <= bin_sh << 1;
          cnt    <= cnt + CNT_W'(1);
          // Publish only the final value so result_bcd never shows a partial conversion.
          if (cnt == CNT_LAST) begin
            result_bcd <= bcd_next;
            done       <= 1'b1;
            state      <= SHOW;
          end
        end
        SHOW: if (press) begin
          result       <= '0;
          led_zero     <= 1'b0;
          led_neg      <= 1'b0;
          led_overflow <= 1'b0;
          result_bcd   <= '0;
          state        <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_sistema_ula_param.sv
// Self-checking bench for sistema_ula_param: a WIDTH=3 instance driven from a
// vector table with a result scoreboard, plus a WIDTH=8 instance for the
// wide multiply case.
module tb_sistema_ula_param;

  localparam logic [2:0] S_LOAD_A  = 3'd0;
  localparam logic [2:0] S_LOAD_B  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_CONVERT = 3'd4;
  localparam logic [2:0] S_SHOW    = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       pb3;
  logic [2:0] sw3, a3, b3, op3, st3;
  logic [5:0] res3;
  logic       z3, n3, o3, busy3, done3;
  logic [7:0] bcd3;

  logic        pb8;
  logic [7:0]  sw8, a8, b8;
  logic [2:0]  op8, st8;
  logic [15:0] res8;
  logic        z8, n8, o8, busy8, done8;
  logic [19:0] bcd8;

  sistema_ula_param #(.WIDTH(3), .DIGITS(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .push_button(pb3), .switches(sw3),
    .a_val(a3), .b_val(b3), .op_val(op3), .state(st3), .result(res3),
    .led_zero(z3), .led_neg(n3), .led_overflow(o3), .result_bcd(bcd3),
    .busy(busy3), .done(done3)
  );

  sistema_ula_param #(.WIDTH(8), .DIGITS(5)) dut8 (
    .clk(clk), .reset_n(reset_n), .push_button(pb8), .switches(sw8),
    .a_val(a8), .b_val(b8), .op_val(op8), .state(st8), .result(res8),
    .led_zero(z8), .led_neg(n8), .led_overflow(o8), .result_bcd(bcd8),
    .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [2:0] a, b, op;
    logic [5:0] res;
    logic       z, n, o;
    logic [7:0] bcd;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];
  vec_t mon_e;
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic [2:0] a, b, op, input logic [5:0] res,
                              input logic z, n, o, input logic [7:0] bcd);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res;
    v.z = z; v.n = n; v.o = o; v.bcd = bcd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected record.
  always @(negedge clk) begin
    if (done3) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: done pulse with no expected result");
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(res3), 32'(mon_e.res));
        chk("zero", 32'(z3), 32'(mon_e.z));
        chk("neg", 32'(n3), 32'(mon_e.n));
        chk("ovf", 32'(o3), 32'(mon_e.o));
        chk("bcd", 32'(bcd3), 32'(mon_e.bcd));
        chk("a_val", 32'(a3), 32'(mon_e.a));
        chk("b_val", 32'(b3), 32'(mon_e.b));
        chk("op_val", 32'(op3), 32'(mon_e.op));
      end
    end
  end

  task automatic press(input int unit, input logic [7:0] v, input int hold, input int tail);
    @(negedge clk);
    if (unit == 3) begin sw3 = v[2:0]; pb3 = 1'b1; end
    else begin sw8 = v; pb8 = 1'b1; end
    repeat (hold) @(negedge clk);
    pb3 = 1'b0;
    pb8 = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  task automatic wait_st(input int unit, input logic [2:0] st, input string name);
    int n = 0;
    while (((unit == 3) ? st3 : st8) != st && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'((unit == 3) ? st3 : st8), 32'(st));
  endtask

  task automatic run_txn(input vec_t v, input int hold_a, input bit inject);
    int n;
    int nb;
    press(3, 8'(v.a), hold_a, 3);
    if (hold_a > 2) begin
      chk("held_state", 32'(st3), 32'(S_LOAD_B));
      chk("held_a", 32'(a3), 32'(v.a));
    end
    press(3, 8'(v.b), 2, 3);
    press(3, 8'(v.op), 2, 0);
    sb.push_back(v);
    wait_st(3, S_EXEC, "reach_exec");
    n = 0;
    nb = busy3 ? 1 : 0;
    while (!done3 && n < 50) begin
      @(negedge clk);
      n++;
      if (busy3) nb++;
      if (inject && n == 1) pb3 = 1'b1;
      if (inject && n == 3) pb3 = 1'b0;
    end
    chk("latency", 32'(n), 32'd7);
    chk("busy_cycles", 32'(nb), 32'd7);
    if (inject) begin
      repeat (4) @(negedge clk);
      chk("show_hold", 32'(st3), 32'(S_SHOW));
    end
    press(3, 8'd0, 2, 3);
    chk("clr_state", 32'(st3), 32'(S_LOAD_A));
    chk("clr_result", 32'(res3), 32'd0);
    chk("clr_bcd", 32'(bcd3), 32'd0);
    chk("clr_flags", 32'({z3, n3, o3}), 32'd0);
    chk("keep_a", 32'(a3), 32'(v.a));
    chk("keep_b", 32'(b3), 32'(v.b));
    chk("keep_op", 32'(op3), 32'(v.op));
  endtask

  initial begin
    int n;
    int nb;
    vecs[0]  = mk(3'd5, 3'd3, 3'b000, 6'd8,       1'b0, 1'b0, 1'b1, 8'h08);
    vecs[1]  = mk(3'd2, 3'd5, 3'b001, 6'b111101,  1'b0, 1'b1, 1'b0, 8'h03);
    vecs[2]  = mk(3'd7, 3'd7, 3'b110, 6'd49,      1'b0, 1'b0, 1'b1, 8'h49);
    vecs[3]  = mk(3'd5, 3'd2, 3'b010, 6'd0,       1'b1, 1'b0, 1'b0, 8'h00);
    vecs[4]  = mk(3'd6, 3'd3, 3'b011, 6'd7,       1'b0, 1'b0, 1'b0, 8'h07);
    vecs[5]  = mk(3'd6, 3'd3, 3'b100, 6'd5,       1'b0, 1'b0, 1'b0, 8'h05);
    vecs[6]  = mk(3'd5, 3'd1, 3'b101, 6'd2,       1'b0, 1'b0, 1'b0, 8'h02);
    vecs[7]  = mk(3'd7, 3'd3, 3'b111, 6'd56,      1'b0, 1'b0, 1'b1, 8'h56);
    vecs[8]  = mk(3'd1, 3'd6, 3'b111, 6'd4,       1'b0, 1'b0, 1'b0, 8'h04);
    vecs[9]  = mk(3'd5, 3'd5, 3'b001, 6'd0,       1'b1, 1'b0, 1'b0, 8'h00);
    vecs[10] = mk(3'd3, 3'd4, 3'b000, 6'd7,       1'b0, 1'b0, 1'b0, 8'h07);
    vecs[11] = mk(3'd7, 3'd0, 3'b001, 6'd7,       1'b0, 1'b0, 1'b0, 8'h07);
    vecs[12] = mk(3'd0, 3'd7, 3'b110, 6'd0,       1'b1, 1'b0, 1'b0, 8'h00);
    vecs[13] = mk(3'd0, 3'd7, 3'b001, 6'b111001,  1'b0, 1'b1, 1'b0, 8'h07);

    reset_n = 1'b0;
    pb3 = 1'b0; sw3 = '0;
    pb8 = 1'b0; sw8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_state3", 32'(st3), 32'(S_LOAD_A));
    chk("rst_out3", 32'({a3, b3, op3, res3, z3, n3, o3, busy3, done3}), 32'd0);
    chk("rst_bcd3", 32'(bcd3), 32'd0);
    chk("rst_state8", 32'(st8), 32'(S_LOAD_A));
    chk("rst_res8", 32'(res8), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], 2, 1'b0);

    // Button held for 20 cycles in LOAD_A loads A exactly once.
    run_txn(mk(3'd4, 3'd1, 3'b000, 6'd5, 1'b0, 1'b0, 1'b0, 8'h05), 20, 1'b0);
    // Press during CONVERT is discarded.
    run_txn(mk(3'd6, 3'd3, 3'b110, 6'd18, 1'b0, 1'b0, 1'b1, 8'h18), 2, 1'b1);

    // Reset in the middle of a conversion.
    press(3, 8'd3, 2, 3);
    press(3, 8'd4, 2, 3);
    press(3, 8'd0, 2, 0);
    wait_st(3, S_CONVERT, "reach_convert");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", 32'(st3), 32'(S_LOAD_A));
    chk("midrst_out", 32'({a3, b3, op3, res3, z3, n3, o3, busy3, done3}), 32'd0);
    chk("midrst_bcd", 32'(bcd3), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(mk(3'd5, 3'd2, 3'b010, 6'd0, 1'b1, 1'b0, 1'b0, 8'h00), 2, 1'b0);

    // Wide instance: 255*255.
    press(8, 8'd255, 2, 3);
    press(8, 8'd255, 2, 3);
    press(8, 8'd6, 2, 0);
    wait_st(8, S_EXEC, "w8_exec");
    n = 0;
    nb = busy8 ? 1 : 0;
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
    end
    chk("w8_latency", 32'(n), 32'd17);
    chk("w8_busy", 32'(nb), 32'd17);
    chk("w8_result", 32'(res8), 32'd65025);
    chk("w8_bcd", 32'(bcd8), 32'h65025);
    chk("w8_flags", 32'({z8, n8, o8}), 32'b001);
    chk("w8_a", 32'(a8), 32'd255);
    chk("w8_b", 32'(b8), 32'd255);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sistema_ula_param.md
# sistema_ula_param

Parametrised successor to the 3-bit push-button ALU system. The operator keys operand A, operand B and the opcode onto `switches` one push at a time. The block then executes the operation and registers the result and flags. A sequential double-dabble converter turns the result magnitude into packed BCD for the 7-segment decoders that sit downstream.

## Interface
Parameters:
- `WIDTH`, default 3: operand width; legal range 3..8.
- `DIGITS`, default 2: BCD digits of the result. Must cover `(2^WIDTH-1)^2`, e.g. 5 for WIDTH=8.
- `RES_W`: localparam, `2*WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `push_button`  in  1  raw, asynchronous button, active-high; already debounced externally.
- `switches`  in  WIDTH  operand/opcode entry; opcode uses `switches[2:0]`.
- `a_val`, `b_val`  out  WIDTH  latched operands.
- `op_val`  out  3  latched opcode.
- `state`  out  3  current FSM state code.
- `result`  out  RES_W  registered two's-complement result.
- `led_zero`, `led_neg`, `led_overflow`  out  1  registered flags.
- `result_bcd`  out  4*DIGITS  magnitude of `result`, packed BCD, digit 0 in [3:0].
- `busy`  out  1  high in EXEC and CONVERT.
- `done`  out  1  one-cycle pulse on entry to SHOW.

## Operation
- **Button path.** Two-flop synchroniser, then a previous-value register.
  - `press = sync2 & ~prev`: one pulse per rising edge.
  - A held button generates no further presses.
- **FSM states:** LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, CONVERT=4, SHOW=5.
  - LOAD_A + press: `a_val<=switches`, go to LOAD_B.
  - LOAD_B + press: `b_val<=switches`, go to LOAD_OP.
  - LOAD_OP + press: `op_val<=switches[2:0]`, go to EXEC.
  - EXEC: unconditional, 1 cycle. Register `result` and the flags, load the converter, go to CONVERT.
  - CONVERT: RES_W shift iterations, then go to SHOW.
  - SHOW + press: clear `result`, flags and `result_bcd` to 0, go to LOAD_A. `a_val`, `b_val` and `op_val` are retained.
  - Presses in EXEC or CONVERT are discarded, not queued.
- **Opcodes.** Operands are unsigned and zero-extended to RES_W.
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A, WIDTH bits.
  - 110 MUL: A*B.
  - 111 SHL: A<<B[1:0].
- **Flags:**
  - `led_zero`: `result==0`.
  - `led_neg`: SUB with A<B, in which case `result` is the RES_W-bit two's complement. 0 for all other opcodes.
  - `led_overflow`: unsigned magnitude of the result ≥ 2^WIDTH, i.e. it does not fit the operand width. 0 for SUB, AND, OR, XOR and NOT.
- **BCD conversion.**
  - Input is `|result|`: the negation of `result` when `led_neg`=1.
  - Per iteration: add 3 to each digit ≥5, then shift left one bit.
  - `result_bcd` updates only on leaving CONVERT; it is never visible mid-conversion.

## Timing
- **Reset (reset_n=0).** Applies immediately, at any state including mid-CONVERT:
  - state=LOAD_A;
  - all outputs 0;
  - synchroniser and previous-value registers 0.
- **Press latency.** If `push_button` is sampled high at edge k, `press` is high between edges k+1 and k+2, and the load or transition happens at edge k+2.
- **EXEC to SHOW.**
  - EXEC lasts 1 cycle; CONVERT lasts exactly RES_W cycles.
  - `done` is high for the first cycle of SHOW only.
  - Total from the LOAD_OP load edge to `done`: 1+RES_W cycles (7 cycles for WIDTH=3).
- **`busy`** is high for exactly 1+RES_W cycles.
- **Release and press on one edge.** A release and a new press falling on the same synchronised edge are impossible by construction: at most one press per two cycles.

## Test plan
- **ADD, overflow.** WIDTH=3: A=5, B=3, OP=000 → `result`=8, `result_bcd`=0x08, zero/neg/ovf=0/0/1, `done` 7 cycles after the OP load.
- **SUB, negative.** WIDTH=3: A=2, B=5, OP=001 → `result`=6'b111101, `led_neg`=1, `result_bcd`=0x03, `led_overflow`=0.
- **MUL, then clear.** WIDTH=3: A=7, B=7, OP=110 → `result`=49, `result_bcd`=0x49, `led_overflow`=1. A SHOW press then zeroes `result` and `result_bcd` and returns to LOAD_A.
- **Ignored press and held button.** Press during CONVERT → state sequence unchanged and no extra load. Holding the button for 20 cycles in LOAD_A → exactly one load.
- **Reset mid-CONVERT.** `reset_n` low during CONVERT → all outputs 0 and state=LOAD_A immediately. A subsequent AND 5&2 → `result`=0, `led_zero`=1.
- **WIDTH=8 MUL.** WIDTH=8, DIGITS=5: A=255, B=255, MUL → `result`=65025, `result_bcd`=0x65025, `busy` high for 17 cycles.
